// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command controller: parser
// states, command codes, error codes and the baud-rate select encoding.
package uart_cmd_pkg;

    // Parser states; every state except ST_IDLE counts as busy.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GET_CMD = 3'd1,
        ST_GET_D0  = 3'd2,
        ST_GET_D1  = 3'd3,
        ST_GET_CHK = 3'd4,
        ST_EXEC    = 3'd5
    } cmdState_t;

    // Command codes carried in the CMD byte of a frame.
    localparam logic [7:0] CMD_SEG  = 8'h01;
    localparam logic [7:0] CMD_PWM  = 8'h02;
    localparam logic [7:0] CMD_LED  = 8'h03;
    localparam logic [7:0] CMD_RATE = 8'h04;

    // Error codes reported on oErrCode.
    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CHK  = 2'd1;
    localparam logic [1:0] ERR_CMD  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    // Baud-rate select values driven on oRate.
    typedef enum logic [1:0] {
        RATE_9600   = 2'd0,
        RATE_19200  = 2'd1,
        RATE_57600  = 2'd2,
        RATE_115200 = 2'd3
    } rateSel_t;

    // Counter width for a timeout of 'cycles' clocks; never below one bit.
    function automatic int cntWidth(input int unsigned cycles);
        if (cycles > 1) begin
            return $clog2(cycles);
        end
        return 1;
    endfunction

    // True for the command codes the controller knows how to execute.
    function automatic logic isKnownCmd(input logic [7:0] code);
        return (code >= CMD_SEG) && (code <= CMD_RATE);
    endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout: a loadable down-counter. Loading restarts the gap
// window, clear parks it at zero, and expire is raised while enabled and
// the count has run down to zero.
module uart_cmd_timeout
    import uart_cmd_pkg::*;
#(
    parameter int unsigned LOAD_VAL = 999_999,
    parameter int          W        = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic clear,
    input  logic en,
    output logic expire
);

    localparam logic [W-1:0] LOAD_W = W'(LOAD_VAL);
    localparam logic [W-1:0] ONE_W  = W'(1);

    logic [W-1:0] count;

    // Load has priority so an accepted byte always restarts the window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_W;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != '0)) begin
            count <= count - ONE_W;
        end
    end

    // Expiry is reported on the cycle the count sits at zero while running.
    assign expire = en && (count == '0);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Command controller behind the UART receiver. Parses 5-byte frames
// (HDR, CMD, D0, D1, CHK with CHK = CMD ^ D0 ^ D1), checks them, and is
// the only writer of the display, PWM, LED and baud-rate registers.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned TIMEOUT_MS = 10,
    parameter logic [7:0]  HDR_BYTE   = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  iRxData,
    input  logic        iRxValid,
    input  logic        iRxErr,
    output logic [15:0] oSegData,
    output logic [7:0]  oPwmDuty,
    output logic [7:0]  oLedPat,
    output logic [1:0]  oRate,
    output logic        oCmdDone,
    output logic        oCmdErr,
    output logic [1:0]  oErrCode,
    output logic        oBusy
);

    // Gap allowed between two bytes of one frame, in clock cycles.
    localparam int unsigned TO_CYC = CLK_FREQ / 1000 * TIMEOUT_MS;
    localparam int          TO_W   = cntWidth(TO_CYC);

    cmdState_t  state;
    rateSel_t   rateReg;
    logic [7:0] cmdReg;
    logic [7:0] d0Reg;
    logic [7:0] d1Reg;

    logic inGet;
    logic hdrSeen;
    logic accept;
    logic tmoClear;
    logic tmoExpire;

    // Byte classification shared by the FSM and the timeout counter.
    // Outside GET_* only a header byte counts (EXEC uses IDLE rules);
    // inside GET_* any byte counts unless a framing error arrives with it.
    assign inGet    = (state == ST_GET_CMD) || (state == ST_GET_D0) ||
                      (state == ST_GET_D1)  || (state == ST_GET_CHK);
    assign hdrSeen  = iRxValid && (iRxData == HDR_BYTE);
    assign accept   = inGet ? (iRxValid && !iRxErr) : hdrSeen;
    assign tmoClear = !inGet;

    uart_cmd_timeout #(
        .LOAD_VAL (TO_CYC - 1),
        .W        (TO_W)
    ) uTimeout (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .clear  (tmoClear),
        .en     (inGet),
        .expire (tmoExpire)
    );

    // Parser FSM plus the configuration register file it owns.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cmdReg   <= '0;
            d0Reg    <= '0;
            d1Reg    <= '0;
            oSegData <= '0;
            oPwmDuty <= '0;
            oLedPat  <= '0;
            rateReg  <= RATE_9600;
            oCmdDone <= 1'b0;
            oCmdErr  <= 1'b0;
            oErrCode <= ERR_NONE;
        end else begin
            oCmdDone <= 1'b0;
            oCmdErr  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Non-header bytes and framing errors are dropped silently.
                    if (hdrSeen) begin
                        state <= ST_GET_CMD;
                    end
                end

                ST_GET_CMD, ST_GET_D0, ST_GET_D1, ST_GET_CHK: begin
                    if (iRxErr) begin
                        // A framing error beats a byte in the same cycle.
                        oCmdErr  <= 1'b1;
                        oErrCode <= ERR_TMO;
                        state    <= ST_IDLE;
                    end else if (iRxValid) begin
                        // A byte wins over a timeout in the same cycle.
                        case (state)
                            ST_GET_CMD: begin
                                cmdReg <= iRxData;
                                state  <= ST_GET_D0;
                            end
                            ST_GET_D0: begin
                                d0Reg <= iRxData;
                                state <= ST_GET_D1;
                            end
                            ST_GET_D1: begin
                                d1Reg <= iRxData;
                                state <= ST_GET_CHK;
                            end
                            default: begin
                                if (iRxData != (cmdReg ^ d0Reg ^ d1Reg)) begin
                                    oCmdErr  <= 1'b1;
                                    oErrCode <= ERR_CHK;
                                    state    <= ST_IDLE;
                                end else if (!isKnownCmd(cmdReg)) begin
                                    oCmdErr  <= 1'b1;
                                    oErrCode <= ERR_CMD;
                                    state    <= ST_IDLE;
                                end else begin
                                    state <= ST_EXEC;
                                end
                            end
                        endcase
                    end else if (tmoExpire) begin
                        oCmdErr  <= 1'b1;
                        oErrCode <= ERR_TMO;
                        state    <= ST_IDLE;
                    end
                end

                ST_EXEC: begin
                    // Only the addressed register changes; rate moves only here,
                    // between bytes, so the receiver picks it up at a start bit.
                    case (cmdReg)
                        CMD_SEG:  oSegData <= {d1Reg, d0Reg};
                        CMD_PWM:  oPwmDuty <= d0Reg;
                        CMD_LED:  oLedPat  <= d0Reg;
                        CMD_RATE: rateReg  <= rateSel_t'(d0Reg[1:0]);
                        default:  ;
                    endcase
                    oCmdDone <= 1'b1;
                    oErrCode <= ERR_NONE;
                    // A header arriving now starts the next frame immediately.
                    state    <= hdrSeen ? ST_GET_CMD : ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign oRate = rateReg;
    assign oBusy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl, run with a 100-cycle inter-byte timeout.
module tb_uart_cmd_ctrl;

    localparam int unsigned TB_CLK_FREQ   = 100_000;
    localparam int unsigned TB_TIMEOUT_MS = 1;
    localparam int          TO_CYC        = 100;

    logic        clk;
    logic        reset;
    logic [7:0]  iRxData;
    logic        iRxValid;
    logic        iRxErr;
    logic [15:0] oSegData;
    logic [7:0]  oPwmDuty;
    logic [7:0]  oLedPat;
    logic [1:0]  oRate;
    logic        oCmdDone;
    logic        oCmdErr;
    logic [1:0]  oErrCode;
    logic        oBusy;

    int nTests = 0;
    int nFail  = 0;
    int earlyErr;

    uart_cmd_ctrl #(
        .CLK_FREQ   (TB_CLK_FREQ),
        .TIMEOUT_MS (TB_TIMEOUT_MS),
        .HDR_BYTE   (8'hA5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .iRxData  (iRxData),
        .iRxValid (iRxValid),
        .iRxErr   (iRxErr),
        .oSegData (oSegData),
        .oPwmDuty (oPwmDuty),
        .oLedPat  (oLedPat),
        .oRate    (oRate),
        .oCmdDone (oCmdDone),
        .oCmdErr  (oCmdErr),
        .oErrCode (oErrCode),
        .oBusy    (oBusy)
    );

    // Clock: 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle byte strobe; returns 1 ns after the edge that sampled it.
    task automatic sendByte(input logic [7:0] b);
        @(posedge clk);
        #1;
        iRxData  = b;
        iRxValid = 1'b1;
        @(posedge clk);
        #1;
        iRxValid = 1'b0;
    endtask

    task automatic sendFrame(input logic [7:0] cmd, input logic [7:0] d0,
                             input logic [7:0] d1, input logic [7:0] chk);
        sendByte(8'hA5);
        sendByte(cmd);
        sendByte(d0);
        sendByte(d1);
        sendByte(chk);
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, ".seg"},  oSegData, 0);
        check({tag, ".pwm"},  oPwmDuty, 0);
        check({tag, ".led"},  oLedPat,  0);
        check({tag, ".rate"}, oRate,    0);
        check({tag, ".done"}, oCmdDone, 0);
        check({tag, ".err"},  oCmdErr,  0);
        check({tag, ".code"}, oErrCode, 0);
        check({tag, ".busy"}, oBusy,    0);
    endtask

    initial begin
        reset    = 1'b1;
        iRxData  = 8'h00;
        iRxValid = 1'b0;
        iRxErr   = 1'b0;
        repeat (3) step();
        checkAllZero("reset");
        reset = 1'b0;
        step();

        // PWM frame: register changes 2 clocks after the CHK strobe.
        sendFrame(8'h02, 8'h80, 8'h00, 8'h82);
        check("pwm.exec_busy", oBusy, 1);
        check("pwm.not_yet", oPwmDuty, 8'h00);
        step();
        check("pwm.value", oPwmDuty, 8'h80);
        check("pwm.done", oCmdDone, 1);
        check("pwm.code", oErrCode, 0);
        check("pwm.err", oCmdErr, 0);
        check("pwm.seg", oSegData, 0);
        check("pwm.led", oLedPat, 0);
        check("pwm.rate", oRate, 0);
        check("pwm.idle", oBusy, 0);
        step();
        check("pwm.done_once", oCmdDone, 0);

        // Segment frame, then rate frame leaves the segment value alone.
        sendFrame(8'h01, 8'h34, 8'h12, 8'h27);
        step();
        check("seg.value", oSegData, 16'h1234);
        sendFrame(8'h04, 8'h03, 8'h00, 8'h07);
        step();
        check("rate.value", oRate, 2'd3);
        check("rate.seg_hold", oSegData, 16'h1234);
        check("rate.pwm_hold", oPwmDuty, 8'h80);

        // Bad checksum, then the corrected frame.
        sendFrame(8'h03, 8'hFF, 8'h00, 8'h00);
        check("chk.err", oCmdErr, 1);
        check("chk.code", oErrCode, 1);
        check("chk.idle", oBusy, 0);
        step();
        check("chk.err_pulse", oCmdErr, 0);
        check("chk.code_hold", oErrCode, 1);
        check("chk.led_hold", oLedPat, 8'h00);
        sendFrame(8'h03, 8'hFF, 8'h00, 8'hFC);
        step();
        check("led.value", oLedPat, 8'hFF);
        check("led.code", oErrCode, 0);
        check("led.done", oCmdDone, 1);

        // Stray byte ignored, then an unknown command.
        sendByte(8'h55);
        check("stray.err", oCmdErr, 0);
        check("stray.idle", oBusy, 0);
        sendFrame(8'h09, 8'h00, 8'h00, 8'h09);
        check("unk.err", oCmdErr, 1);
        check("unk.code", oErrCode, 2);

        // Header value inside a frame is plain data.
        sendFrame(8'h03, 8'hA5, 8'h00, 8'hA6);
        step();
        check("hdrdata.led", oLedPat, 8'hA5);

        // Timeout: error appears TO_CYC clocks after the last byte.
        sendByte(8'hA5);
        sendByte(8'h02);
        earlyErr = 0;
        for (int i = 1; i < TO_CYC; i++) begin
            step();
            if (oCmdErr !== 1'b0 || oBusy !== 1'b1) earlyErr++;
        end
        check("tmo.early", earlyErr, 0);
        step();
        check("tmo.err", oCmdErr, 1);
        check("tmo.code", oErrCode, 3);
        check("tmo.idle", oBusy, 0);
        sendFrame(8'h02, 8'h10, 8'h00, 8'h12);
        step();
        check("tmo.recover", oPwmDuty, 8'h10);
        check("tmo.recover_code", oErrCode, 0);

        // Framing error mid-frame aborts with code 3.
        sendByte(8'hA5);
        sendByte(8'h02);
        iRxErr = 1'b1;
        step();
        iRxErr = 1'b0;
        check("rxerr.err", oCmdErr, 1);
        check("rxerr.code", oErrCode, 3);
        check("rxerr.idle", oBusy, 0);

        // Framing error in IDLE is ignored.
        iRxErr = 1'b1;
        step();
        iRxErr = 1'b0;
        check("rxerr_idle.err", oCmdErr, 0);

        // Framing error together with a byte: error wins, byte dropped.
        sendByte(8'hA5);
        sendByte(8'h02);
        iRxErr   = 1'b1;
        iRxValid = 1'b1;
        iRxData  = 8'h44;
        step();
        iRxErr   = 1'b0;
        iRxValid = 1'b0;
        check("rxerr_both.err", oCmdErr, 1);
        check("rxerr_both.idle", oBusy, 0);
        check("rxerr_both.pwm", oPwmDuty, 8'h10);

        // Back-to-back: header strobed during EXEC starts the next frame.
        sendFrame(8'h01, 8'h78, 8'h56, 8'h2F);
        iRxData  = 8'hA5;
        iRxValid = 1'b1;
        step();
        iRxValid = 1'b0;
        check("b2b.seg", oSegData, 16'h5678);
        check("b2b.done", oCmdDone, 1);
        check("b2b.busy", oBusy, 1);
        sendByte(8'h02);
        sendByte(8'h22);
        sendByte(8'h00);
        sendByte(8'h20);
        step();
        check("b2b.pwm", oPwmDuty, 8'h22);

        // Asynchronous reset mid-frame clears everything before any edge.
        sendByte(8'hA5);
        sendByte(8'h01);
        sendByte(8'h34);
        check("rst.busy_before", oBusy, 1);
        #3;
        reset = 1'b1;
        #1;
        checkAllZero("rst_async");
        step();
        reset = 1'b0;
        sendByte(8'h12);
        sendByte(8'h27);
        repeat (3) step();
        check("rst.seg", oSegData, 0);
        check("rst.err", oCmdErr, 0);
        check("rst.done", oCmdDone, 0);
        check("rst.busy", oBusy, 0);
        sendFrame(8'h01, 8'h34, 8'h12, 8'h27);
        step();
        check("rst.recover", oSegData, 16'h1234);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
